// File: rtl/mobius_stream_loader.sv
// rtl/mobius_stream_loader.sv - stream-to-vector loader and result collector for the Mobius transform stage
//
// Assembles an N-bit truth table from W-bit beats (MSB first), strobes it into
// the transform with vec_load, waits LATENCY cycles, captures the transform
// result and offers it downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input beat handshake; in_data is one W-bit beat, in_last ends a table
//   vec_out, vec_load     assembled vector [0:N-1] and one-cycle load strobe to the transform
//   res_in                transform output [0:N-1]
//   res_valid/res_ready   result handshake; res_data is the captured result [0:N-1]
//   err_len               sticky beat-count / in_last mismatch flag
//   res_weight            popcount of the captured result (only with MOBIUS_LOADER_WEIGHT_EN)
//
// Optional feature macro: MOBIUS_LOADER_WEIGHT_EN

module mobius_stream_loader #(
    parameter int N       = 64,
    parameter int LOG2_N  = 6,
    parameter int W       = 8,
    parameter int LATENCY = LOG2_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    output logic [0:N-1]      vec_out,
    output logic              vec_load,
    input  logic [0:N-1]      res_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [0:N-1]      res_data,
`ifdef MOBIUS_LOADER_WEIGHT_EN
    output logic [LOG2_N:0]   res_weight,
`endif
    output logic              err_len
);

    localparam int WORDS = N / W;
    localparam int BW    = $clog2(WORDS + 1);
    localparam int CW    = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_LAT  = CW'(LATENCY - 1);

    logic [1:0]     state_q, state_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [0:N-1]   vec_out_q, vec_out_d;
    logic           vec_load_q, vec_load_d;
    logic [0:N-1]   res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           err_len_q, err_len_d;
    logic           final_beat;

`ifdef MOBIUS_LOADER_WEIGHT_EN
    logic [LOG2_N:0] res_weight_q, res_weight_d;
    logic [LOG2_N:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{LOG2_N{1'b0}}, res_in[i]};
        end
    end
`endif

    assign in_ready   = (state_q == ST_FILL);
    assign final_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        vec_out_d   = vec_out_q;
        vec_load_d  = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        err_len_d   = err_len_q;
`ifdef MOBIUS_LOADER_WEIGHT_EN
        res_weight_d = res_weight_q;
`endif
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    // Current beat lands in its word; an early in_last zeroes the words it skips.
                    for (int j = 0; j < WORDS; j++) begin
                        if (BW'(j) == beat_cnt_q) begin
                            vec_out_d[j*W +: W] = in_data;
                        end else if (in_last && (BW'(j) > beat_cnt_q)) begin
                            vec_out_d[j*W +: W] = '0;
                        end
                    end
                    if (final_beat || in_last) begin
                        state_d    = ST_LOAD;
                        vec_load_d = 1'b1;
                        beat_cnt_d = '0;
                        if (final_beat != in_last) begin
                            err_len_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d   = ST_RUN;
                lat_cnt_d = '0;
            end
            ST_RUN: begin
                // Capture lands LATENCY edges after the edge that sampled vec_load.
                if (lat_cnt_q == LAST_LAT) begin
                    res_data_d  = res_in;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    lat_cnt_d   = '0;
`ifdef MOBIUS_LOADER_WEIGHT_EN
                    res_weight_d = pop;
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_FILL;
                    beat_cnt_d  = '0;
                    lat_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            beat_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            vec_out_q   <= '0;
            vec_load_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
`ifdef MOBIUS_LOADER_WEIGHT_EN
            res_weight_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            vec_out_q   <= vec_out_d;
            vec_load_q  <= vec_load_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            err_len_q   <= err_len_d;
`ifdef MOBIUS_LOADER_WEIGHT_EN
            res_weight_q <= res_weight_d;
`endif
        end
    end

    assign vec_out   = vec_out_q;
    assign vec_load  = vec_load_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign err_len   = err_len_q;
`ifdef MOBIUS_LOADER_WEIGHT_EN
    assign res_weight = res_weight_q;
`endif

endmodule

// File: tb/tb_mobius_stream_loader.sv
// tb/tb_mobius_stream_loader.sv - directed self-checking bench for mobius_stream_loader

module tb_mobius_stream_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [0:63]  vec_out;
    logic         vec_load;
    logic [0:63]  res_in;
    logic         res_valid;
    logic         res_ready;
    logic [0:63]  res_data;
    logic         err_len;
`ifdef MOBIUS_LOADER_WEIGHT_EN
    logic [6:0]   res_weight;
`endif

    int vectors   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mobius_stream_loader #(.N(64), .LOG2_N(6), .W(8), .LATENCY(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .vec_out   (vec_out),
        .vec_load  (vec_load),
        .res_in    (res_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef MOBIUS_LOADER_WEIGHT_EN
        .res_weight(res_weight),
`endif
        .err_len   (err_len)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Runs LOAD + RUN to HOLD and then acknowledges the result.
    task automatic drain_result();
        repeat (7) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        repeat (3) tick();
        vectors++;
        if ({vec_load, res_valid, err_len} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got=%b exp=000", {vec_load, res_valid, err_len});
        end
        vectors++;
        if (vec_out !== 64'h0 || res_data !== 64'h0) begin
            miscompares++; $display("FAIL reset_data vec_out=%h res_data=%h exp=0", vec_out, res_data);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_transfer();
        logic load_seen;
        res_in = 64'hA5A5_A5A5_A5A5_A5A5;
        send_beat(8'h80, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(8'h00, 1'b0);
        send_beat(8'h01, 1'b1);
        vectors++;
        if (vec_load !== 1'b1) begin miscompares++; $display("FAIL basic_vec_load_on got=%b exp=1", vec_load); end
        vectors++;
        if (vec_out !== 64'h8000_0000_0000_0001) begin
            miscompares++; $display("FAIL basic_vec_out got=%h exp=8000000000000001", vec_out);
        end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_load_in_ready got=%b exp=0", in_ready); end
        tick();
        vectors++;
        if (vec_load !== 1'b0) begin miscompares++; $display("FAIL basic_vec_load_off got=%b exp=0", vec_load); end
        load_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid !== 1'b0 || vec_load !== 1'b0) load_seen = 1'b1;
        end
        vectors++;
        if (load_seen !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got=1 exp=0"); end
        tick();
        vectors++;
        if (res_valid !== 1'b1) begin miscompares++; $display("FAIL basic_res_valid got=%b exp=1", res_valid); end
        vectors++;
        if (res_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            miscompares++; $display("FAIL basic_res_data got=%h exp=a5a5a5a5a5a5a5a5", res_data);
        end
        vectors++;
        if (err_len !== 1'b0) begin miscompares++; $display("FAIL basic_err_len got=%b exp=0", err_len); end
    endtask

    task automatic test_backpressure();
        logic bad;
        bad = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        res_in   = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== 64'hA5A5_A5A5_A5A5_A5A5) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++; $display("FAIL hold_stable valid=%b ready=%b data=%h", res_valid, in_ready, res_data);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL hold_release valid=%b in_ready=%b exp=0/1", res_valid, in_ready);
        end
        vectors++;
        if (vec_out !== 64'h8000_0000_0000_0001) begin
            miscompares++; $display("FAIL hold_vec_kept got=%h exp=8000000000000001", vec_out);
        end
    endtask

    task automatic test_short_vector();
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b1);
        vectors++;
        if (vec_out !== 64'hFFFF_FF00_0000_0000) begin
            miscompares++; $display("FAIL short_vec_out got=%h exp=ffffff0000000000", vec_out);
        end
        vectors++;
        if (err_len !== 1'b1 || vec_load !== 1'b1) begin
            miscompares++; $display("FAIL short_flags err_len=%b vec_load=%b exp=1/1", err_len, vec_load);
        end
        drain_result();
        for (int i = 0; i < 7; i++) send_beat(8'(i + 1), 1'b0);
        send_beat(8'h08, 1'b1);
        vectors++;
        if (vec_out !== 64'h0102_0304_0506_0708) begin
            miscompares++; $display("FAIL short_next_vec got=%h exp=0102030405060708", vec_out);
        end
        drain_result();
        vectors++;
        if (err_len !== 1'b1) begin miscompares++; $display("FAIL short_sticky got=%b exp=1", err_len); end
    endtask

    task automatic test_reset_in_run();
        logic bad;
        for (int i = 0; i < 7; i++) send_beat(8'hAA, 1'b0);
        send_beat(8'hAA, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({in_ready, vec_load, res_valid, err_len} !== 4'b1000) begin
            miscompares++; $display("FAIL rst_run_flags got=%b exp=1000", {in_ready, vec_load, res_valid, err_len});
        end
        vectors++;
        if (vec_out !== 64'h0 || res_data !== 64'h0) begin
            miscompares++; $display("FAIL rst_run_data vec_out=%h res_data=%h exp=0", vec_out, res_data);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vec_load !== 1'b0 || res_valid !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin miscompares++; $display("FAIL rst_run_quiet got=1 exp=0"); end
        res_in = 64'hDEAD_BEEF_0BAD_F00D;
        for (int i = 0; i < 7; i++) send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        vectors++;
        if (vec_out !== 64'h1111_1111_1111_1122) begin
            miscompares++; $display("FAIL rst_run_vec got=%h exp=1111111111111122", vec_out);
        end
        repeat (7) tick();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 64'hDEAD_BEEF_0BAD_F00D || err_len !== 1'b0) begin
            miscompares++; $display("FAIL rst_run_result valid=%b data=%h err=%b", res_valid, res_data, err_len);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_missing_last();
        for (int i = 0; i < 8; i++) send_beat(8'h5A, 1'b0);
        vectors++;
        if (err_len !== 1'b1 || vec_load !== 1'b1) begin
            miscompares++; $display("FAIL nolast_flags err_len=%b vec_load=%b exp=1/1", err_len, vec_load);
        end
        drain_result();
    endtask

`ifdef MOBIUS_LOADER_WEIGHT_EN
    task automatic test_weight();
        res_in = {64{1'b1}};
        for (int i = 0; i < 7; i++) send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b1);
        repeat (7) tick();
        vectors++;
        if (res_weight !== 7'd64) begin miscompares++; $display("FAIL weight_all got=%0d exp=64", res_weight); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        res_in = 64'h0000_0000_0000_0001;
        for (int i = 0; i < 7; i++) send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b1);
        repeat (7) tick();
        vectors++;
        if (res_weight !== 7'd1) begin miscompares++; $display("FAIL weight_one got=%0d exp=1", res_weight); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        res_in    = 64'h0;
        res_ready = 1'b0;
        test_reset();
        test_basic_transfer();
        test_backpressure();
        test_short_vector();
        test_reset_in_run();
        test_missing_last();
`ifdef MOBIUS_LOADER_WEIGHT_EN
        test_weight();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
